// File: rtl/bf_bus_host.sv
// Host-side bus agent for the BF chip: follows the chip's serialized IO sequence,
// performs the decoded memory/stdin/stdout access and returns data with op_done.
module bf_bus_host (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] chip_io,
  output logic [9:0]  chip_ctl,
  input  logic        run,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        halted,
  output logic [15:0] txn_count,
  output logic        err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    H_IDLE    = 3'd0,
    H_ADDR_HI = 3'd1,
    H_ADDR_LO = 3'd2,
    H_DATA    = 3'd3,
    H_ACCESS  = 3'd4,
    H_DONE    = 3'd5
  } state_e;

  localparam logic [2:0] IO_NONE    = 3'd0;
  localparam logic [2:0] IO_OPCODE  = 3'd1;
  localparam logic [2:0] IO_ADDR_HI = 3'd2;
  localparam logic [2:0] IO_ADDR_LO = 3'd3;
  localparam logic [2:0] IO_RW      = 3'd4;

  localparam logic [2:0] OP_READ_PROG  = 3'd1;
  localparam logic [2:0] OP_READ_DATA  = 3'd2;
  localparam logic [2:0] OP_WRITE_DATA = 3'd3;
  localparam logic [2:0] OP_READ_IN    = 3'd4;
  localparam logic [2:0] OP_WRITE_OUT  = 3'd5;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] txn_q, txn_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic        halted_q;

  logic [2:0]  io_st;
  logic [7:0]  bus;
  logic        en;
  logic        is_mem;
  logic        acc_done;
  logic        bad_seq;
  logic        abort_now;

  assign io_st  = chip_io[10:8];
  assign bus    = chip_io[7:0];
  assign en     = run;
  assign is_mem = (op_q == OP_READ_PROG) || (op_q == OP_READ_DATA) || (op_q == OP_WRITE_DATA);

  always_comb begin
    case (op_q)
      OP_READ_PROG, OP_READ_DATA, OP_WRITE_DATA: acc_done = mem_ack;
      OP_READ_IN:                                acc_done = in_valid;
      OP_WRITE_OUT:                              acc_done = out_ready;
      default:                                   acc_done = en;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    txn_d     = txn_q;
    err_d     = err_q;
    abort_d   = abort_q;
    bad_seq   = 1'b0;
    abort_now = 1'b0;

    case (state_q)
      H_IDLE: begin
        if (en) begin
          if (io_st == IO_OPCODE) begin
            op_d    = bus[2:0];
            state_d = H_ADDR_HI;
          end else if (io_st != IO_NONE) begin
            bad_seq = 1'b1;
          end
        end
      end
      H_ADDR_HI: begin
        if (en) begin
          if (io_st == IO_ADDR_HI) begin
            addr_d[14:8] = bus[6:0];
            state_d      = H_ADDR_LO;
          end else begin
            bad_seq = 1'b1;
          end
        end
      end
      H_ADDR_LO: begin
        if (en) begin
          if (io_st == IO_ADDR_LO) begin
            addr_d[7:0] = bus;
            state_d     = H_DATA;
          end else begin
            bad_seq = 1'b1;
          end
        end
      end
      H_DATA: begin
        if (en) begin
          if (io_st == IO_RW) begin
            wdata_d = bus;
            state_d = H_ACCESS;
          end else begin
            bad_seq = 1'b1;
          end
        end
      end
      H_ACCESS: begin
        // A chip that restarts mid-access still lets the handshake finish, then drops the result.
        abort_now = en && ((io_st == IO_NONE) || (io_st == IO_OPCODE));
        abort_d   = abort_q || abort_now;
        if (acc_done) begin
          abort_d = 1'b0;
          if (abort_q || abort_now) begin
            err_d   = 1'b1;
            state_d = H_IDLE;
          end else begin
            state_d = H_DONE;
            case (op_q)
              OP_READ_PROG, OP_READ_DATA: rdata_d = mem_rdata;
              OP_READ_IN:                 rdata_d = in_data;
              OP_WRITE_DATA, OP_WRITE_OUT: rdata_d = 8'h00;
              default: begin
                rdata_d = 8'h00;
                err_d   = 1'b1;
              end
            endcase
          end
        end
      end
      H_DONE: begin
        if (en) begin
          txn_d   = txn_q + 16'd1;
          state_d = H_IDLE;
        end
      end
      default: state_d = H_IDLE;
    endcase

    // Out-of-order chip state: flag it and treat this cycle as if seen from idle.
    if (bad_seq) begin
      err_d   = 1'b1;
      state_d = H_IDLE;
      if (io_st == IO_OPCODE) begin
        op_d    = bus[2:0];
        state_d = H_ADDR_HI;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= H_IDLE;
      op_q     <= 3'd0;
      addr_q   <= 15'd0;
      wdata_q  <= 8'd0;
      rdata_q  <= 8'd0;
      txn_q    <= 16'd0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      txn_q   <= txn_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      if (en) begin
        halted_q <= chip_io[11];
      end
    end
  end

  assign mem_req   = (state_q == H_ACCESS) && is_mem;
  assign mem_we    = (state_q == H_ACCESS) && (op_q == OP_WRITE_DATA);
  assign mem_addr  = {op_q == OP_READ_PROG, addr_q};
  assign mem_wdata = wdata_q;
  assign in_ready  = (state_q == H_ACCESS) && (op_q == OP_READ_IN);
  assign out_valid = (state_q == H_ACCESS) && (op_q == OP_WRITE_OUT);
  assign out_data  = wdata_q;

  assign chip_ctl[9]   = run;
  assign chip_ctl[8]   = (state_q == H_DONE);
  assign chip_ctl[7:0] = (state_q == H_DONE) ? rdata_q : 8'h00;

  assign halted    = halted_q;
  assign txn_count = txn_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bf_bus_host.sv
// Directed bench for bf_bus_host: a table of full chip transactions plus
// hand-written sequences for protocol errors, run gating, abort and reset.
module tb_bf_bus_host;

  logic        clock;
  logic        reset_n;
  logic [11:0] chip_io;
  logic [9:0]  chip_ctl;
  logic        run;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        halted;
  logic [15:0] txn_count;
  logic        err;
  logic [2:0]  dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  logic halt_bit = 1'b0;

  bf_bus_host dut (
    .clock(clock), .reset_n(reset_n), .chip_io(chip_io), .chip_ctl(chip_ctl), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .halted(halted), .txn_count(txn_count), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [2:0] IO_NONE = 3'd0, IO_OPCODE = 3'd1, IO_ADDR_HI = 3'd2,
                         IO_ADDR_LO = 3'd3, IO_RW = 3'd4;

  typedef struct {
    int         req_cyc;
    logic       we;
    logic [15:0] addr;
    logic [7:0] wdata;
    int         inr_cyc;
    int         outv_cyc;
    logic [7:0] odata;
    logic       ounstable;
    int         done_cyc;
    logic [7:0] done_data;
    int         done_k;
  } cap_t;

  typedef struct {
    logic [2:0]  op;
    logic [14:0] addr;
    logic [7:0]  wd;
    int          wt;
    logic [7:0]  rd;
    int          exp_req;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    int          exp_inr;
    int          exp_outv;
    logic [7:0]  exp_odata;
    logic [7:0]  exp_data;
    int          exp_k;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_io(input logic [2:0] st, input logic [7:0] b);
    chip_io = {halt_bit, st, b};
  endtask

  task automatic clr_hs();
    mem_ack = 1'b0; mem_rdata = 8'h00; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clr_hs();
    set_io(IO_NONE, 8'h00);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // driver: one complete chip transaction with a responder releasing the handshake at k == wt+1
  task automatic txn(input logic [2:0] op, input logic [14:0] addr, input logic [7:0] wd,
                     input int wt, input logic [7:0] rd, output cap_t c);
    logic seen;
    logic hs;
    c = '{default: 0};
    c.done_k = -1;
    set_io(IO_OPCODE, {5'b0, op}); tick();
    set_io(IO_ADDR_HI, {1'b0, addr[14:8]}); tick();
    set_io(IO_ADDR_LO, addr[7:0]); tick();
    set_io(IO_RW, wd);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      hs = (k == wt + 1);
      mem_ack = hs; mem_rdata = hs ? rd : 8'h00;
      in_valid = hs; in_data = hs ? rd : 8'h00;
      out_ready = hs;
      @(negedge clock);
      if (mem_req) begin c.req_cyc++; c.we = mem_we; c.addr = mem_addr; c.wdata = mem_wdata; end
      if (in_ready) c.inr_cyc++;
      if (out_valid) begin
        if (c.outv_cyc > 0 && out_data !== c.odata) c.ounstable = 1'b1;
        c.outv_cyc++;
        c.odata = out_data;
      end
      if (chip_ctl[8]) begin c.done_cyc++; c.done_data = chip_ctl[7:0]; c.done_k = k; seen = 1'b1; end
      tick();
    end
    clr_hs();
    set_io(IO_NONE, 8'h00);
    @(negedge clock);
    if (chip_ctl[8]) c.done_cyc++;
    tick();
  endtask

  vec_t vecs[6];
  cap_t c;
  int   cnt;

  initial begin
    run = 1'b1;
    reset_n = 1'b0;
    clr_hs();
    set_io(IO_NONE, 8'h00);
    #2;
    // reset state (async, mid-cycle)
    chk("rst_ctl",      chip_ctl, 10'h200);
    chk("rst_mem_req",  mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_txn",      txn_count, 0);
    chk("rst_err",      err, 0);
    chk("rst_halted",   halted, 0);
    chk("rst_state",    dbg_state, 0);
    run = 1'b0;
    #1 chk("rst_enable_follows_run", chip_ctl[9], 0);
    run = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    //          op    addr      wd     wt rd     req we  exp_addr  wdat   inr outv odat   data   k  err
    vecs[0] = '{3'd2, 15'h1234, 8'h00, 2, 8'hA5, 3, 1'b0, 16'h1234, 8'h00, 0, 0, 8'h00, 8'hA5, 4, 1'b0};
    vecs[1] = '{3'd3, 15'h7FFF, 8'h3C, 0, 8'hEE, 1, 1'b1, 16'h7FFF, 8'h3C, 0, 0, 8'h00, 8'h00, 2, 1'b0};
    vecs[2] = '{3'd1, 15'h0005, 8'h00, 1, 8'h5A, 2, 1'b0, 16'h8005, 8'h00, 0, 0, 8'h00, 8'h5A, 3, 1'b0};
    vecs[3] = '{3'd4, 15'h0000, 8'h00, 5, 8'h41, 0, 1'b0, 16'h0000, 8'h00, 6, 0, 8'h00, 8'h41, 7, 1'b0};
    vecs[4] = '{3'd5, 15'h0000, 8'h0A, 3, 8'h77, 0, 1'b0, 16'h0000, 8'h00, 0, 4, 8'h0A, 8'h00, 5, 1'b0};
    vecs[5] = '{3'd7, 15'h0000, 8'h00, 0, 8'hFF, 0, 1'b0, 16'h0000, 8'h00, 0, 0, 8'h00, 8'h00, 2, 1'b1};

    for (int i = 0; i < 6; i++) begin
      txn(vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].wt, vecs[i].rd, c);
      chk($sformatf("v%0d_req_cycles", i), c.req_cyc, vecs[i].exp_req);
      chk($sformatf("v%0d_done_cycles", i), c.done_cyc, 1);
      chk($sformatf("v%0d_done_data", i), c.done_data, vecs[i].exp_data);
      chk($sformatf("v%0d_done_latency", i), c.done_k, vecs[i].exp_k);
      chk($sformatf("v%0d_in_ready_cycles", i), c.inr_cyc, vecs[i].exp_inr);
      chk($sformatf("v%0d_out_valid_cycles", i), c.outv_cyc, vecs[i].exp_outv);
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      chk($sformatf("v%0d_txn_count", i), txn_count, i + 1);
      if (vecs[i].exp_req > 0) begin
        chk($sformatf("v%0d_mem_we", i), c.we, vecs[i].exp_we);
        chk($sformatf("v%0d_mem_addr", i), c.addr, vecs[i].exp_addr);
      end
      if (vecs[i].exp_we) chk($sformatf("v%0d_mem_wdata", i), c.wdata, vecs[i].exp_wdata);
      if (vecs[i].exp_outv > 0) begin
        chk($sformatf("v%0d_out_data", i), c.odata, vecs[i].exp_odata);
        chk($sformatf("v%0d_out_stable", i), c.ounstable, 0);
      end
    end

    // halted lags chip_io[11] by one cycle
    halt_bit = 1'b1;
    set_io(IO_NONE, 8'h00);
    @(negedge clock) chk("halted_lag0", halted, 0);
    tick();
    @(negedge clock) chk("halted_lag1", halted, 1);
    tick();
    halt_bit = 1'b0;
    set_io(IO_NONE, 8'h00);

    // chip skips IoAddrLo
    do_reset();
    set_io(IO_OPCODE, 8'h02); tick();
    set_io(IO_ADDR_HI, 8'h12); tick();
    set_io(IO_RW, 8'h00); tick();
    set_io(IO_NONE, 8'h00);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (mem_req) cnt++;
      tick();
    end
    chk("jump_err", err, 1);
    chk("jump_no_req", cnt, 0);
    chk("jump_state_idle", dbg_state, 0);

    // run dropped while op_done is pending
    do_reset();
    set_io(IO_OPCODE, 8'h02); tick();
    set_io(IO_ADDR_HI, 8'h00); tick();
    set_io(IO_ADDR_LO, 8'h10); tick();
    set_io(IO_RW, 8'h00); tick();
    mem_ack = 1'b1; mem_rdata = 8'h77; tick();
    clr_hs();
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("hold_done_%0d", k), chip_ctl, {2'b01, 8'h77});
      tick();
    end
    chk("hold_txn_frozen", txn_count, 0);
    run = 1'b1;
    @(negedge clock) chk("hold_done_resume", chip_ctl, {2'b11, 8'h77});
    tick();
    set_io(IO_NONE, 8'h00);
    @(negedge clock);
    chk("hold_done_cleared", chip_ctl[8], 0);
    chk("hold_txn", txn_count, 1);
    chk("hold_state_idle", dbg_state, 0);
    tick();

    // chip restarts mid-access: handshake completes, no op_done, err set
    do_reset();
    set_io(IO_OPCODE, 8'h02); tick();
    set_io(IO_ADDR_HI, 8'h00); tick();
    set_io(IO_ADDR_LO, 8'h20); tick();
    set_io(IO_RW, 8'h00); tick();
    set_io(IO_NONE, 8'h00);
    @(negedge clock) chk("abort_req_held", mem_req, 1);
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h99; tick();
    clr_hs();
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (chip_ctl[8]) cnt++;
      tick();
    end
    chk("abort_no_done", cnt, 0);
    chk("abort_err", err, 1);
    chk("abort_txn", txn_count, 0);

    // asynchronous reset in the middle of a write access
    do_reset();
    set_io(IO_OPCODE, 8'h03); tick();
    set_io(IO_ADDR_HI, 8'h43); tick();
    set_io(IO_ADDR_LO, 8'h21); tick();
    set_io(IO_RW, 8'h55); tick();
    @(negedge clock);
    chk("mid_req", {mem_req, mem_we, mem_addr}, {2'b11, 16'h4321});
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", {mem_req, mem_we}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_ctl", chip_ctl[8:0], 0);
    chk("mid_rst_state", dbg_state, 0);
    set_io(IO_NONE, 8'h00);
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bf_bus_host.md
# bf_bus_host

Host-side bus agent sitting directly downstream of the BF chip's 12-bit IO port. It follows the chip's serialized transaction sequence (opcode, address high, address low, read/write), decodes it, and performs the access against one memory port or the stdin/stdout streams. It then returns read data and a one-cycle `op_done` to the chip. It also owns the chip's `enable` line, and exposes halt status, a transaction counter and a sticky protocol-error flag.

## Interface
- No parameters.
- `clock` in 1: system clock, shared with the chip.
- `reset_n` in 1: asynchronous, active-low reset.
- `chip_io` in 12: chip output port; [11] halted, [10:8] chip IO state, [7:0] bus byte.
- `chip_ctl` out 10: chip input port; [9] enable, [8] op_done, [7:0] read data.
- `run` in 1: software run request; chip enable = `run`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 16, `mem_wdata` out 8: memory request. `mem_addr[15]`=1 selects program space; [14:0] is the chip address.
- `mem_ack` in 1, `mem_rdata` in 8: memory completion; `mem_rdata` is valid while `mem_ack`=1.
- `in_valid` in 1, `in_data` in 8, `in_ready` out 1: stdin stream.
- `out_valid` out 1, `out_data` out 8, `out_ready` in 1: stdout stream.
- `halted` out 1: registered copy of `chip_io[11]`.
- `txn_count` out 16: completed transactions, wraps 0xFFFF→0.
- `err` out 1: sticky protocol error.

## Operation
- Chip IO state encoding: 0 IoNone, 1 IoOpcode, 2 IoAddrHi, 3 IoAddrLo, 4 IoReadWrite.
- Opcode encoding (`bus[2:0]` in IoOpcode):
  - 0 None.
  - 1 ReadProg: memory read, space 1.
  - 2 ReadData: memory read, space 0.
  - 3 WriteData: memory write, space 0.
  - 4 ReadIn: stdin.
  - 5 WriteOut: stdout.
  - 6 and 7 are invalid.
- Host FSM states: H_IDLE, H_ADDR_HI, H_ADDR_LO, H_DATA, H_ACCESS, H_DONE.
- All inputs are sampled only on cycles where enable=1; the chip state advances only on those cycles.
- H_IDLE: on IoOpcode, latch `op`=bus[2:0] and go to H_ADDR_HI.
- H_ADDR_HI: on IoAddrHi, latch `addr[14:8]`=bus[6:0] and go to H_ADDR_LO.
- H_ADDR_LO: on IoAddrLo, latch `addr[7:0]` and go to H_DATA.
- H_DATA: on IoReadWrite, latch `wdata`=bus and go to H_ACCESS.
- H_ACCESS performs the decoded access:
  - Memory ops: `mem_req`=1 with `mem_we`, `mem_addr`, `mem_wdata` held stable until the cycle `mem_ack`=1. On that cycle, capture `mem_rdata` (reads only) into `rdata`.
  - ReadIn: `in_ready`=1 until `in_valid`=1. On that cycle, `rdata`=`in_data`.
  - WriteOut: `out_valid`=1 with `out_data`=`wdata` until `out_ready`=1.
  - Opcodes 0, 6, 7: no access, `rdata`=0, `err` set. These take one cycle in H_ACCESS.
  - On completion, go to H_DONE.
- H_DONE:
  - Drive op_done=1 and read data=`rdata`; read data=0 for write ops.
  - Stay in H_DONE until a cycle with enable=1, so the chip sees the pulse.
  - Then increment `txn_count` and go to H_IDLE.
- Out-of-order chip state sets `err` and returns to H_IDLE (re-evaluating the current cycle's IoOpcode). Cases covered:
  - Any non-IoNone state that is not the expected next state.
  - IoNone appearing in H_ADDR_*/H_DATA.
- Abort during H_ACCESS: if the chip shows IoNone or IoOpcode, the access already in flight finishes its handshake. Its result is discarded, no op_done is driven, `err` is set, and the FSM returns to H_IDLE.
- Outside H_DONE, op_done=0 and read data=0.

## Timing
- Reset (`reset_n`=0, asynchronous) drives these values:
  - FSM=H_IDLE.
  - `mem_req`, `mem_we`, `in_ready`, `out_valid`, op_done, `err`, `halted` = 0.
  - `mem_addr`, `mem_wdata`, `out_data`, read data, `txn_count` = 0.
  - chip enable=`run` (combinational, also during reset).
- With `run`=1, let cycle N be the first IoReadWrite cycle:
  - `mem_req`=1 at N+1.
  - If `mem_ack` arrives at N+1, op_done=1 at N+2 and the chip shows IoNone at N+3.
  - Minimum latency from IoOpcode to IoNone: 6 cycles.
- Each extra memory or stream wait cycle adds exactly one cycle.
- `txn_count` updates on the clock edge that leaves H_DONE.
- `halted` lags `chip_io[11]` by one cycle.
- `run`=0 freezes the FSM (except H_ACCESS handshakes, which still complete) and holds all outputs.

## Test plan
- ReadData at addr 0x1234, `mem_ack` after 2 wait cycles with `mem_rdata`=0xA5:
  - `mem_addr`=0x1234, `mem_we`=0.
  - op_done one cycle with read data 0xA5.
  - `txn_count`=1.
- WriteData at addr 0x7FFF with value 0x3C: one `mem_req` with `mem_we`=1, `mem_addr`=0x7FFF, `mem_wdata`=0x3C; op_done with read data 0x00.
- ReadProg at addr 0x0005: `mem_addr`=0x8005.
- ReadIn with `in_valid` delayed 5 cycles and `in_data`=0x41: `in_ready` held 6 cycles; op_done with read data 0x41.
- WriteOut 0x0A with `out_ready` low for 3 cycles: `out_valid` held stable with `out_data`=0x0A; single op_done; no `err`.
- Opcode 7: `err`=1 and op_done with read data 0.
- Chip jumps IoAddrHi→IoReadWrite: `err`=1, no memory request.
- `run` dropped during H_DONE: op_done is held until `run` returns, then the chip reaches IoNone.
- `reset_n` pulsed mid-H_ACCESS: all outputs return to their reset values immediately.
